hist_write_checker: RTL and testbench

//  Synthesizable scoreboard for a multi-lane scratch-memory write stream.

---
 rtl/hist_write_checker.sv | 171 +++++++++++++++++
 tb/tb_hist_write_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_write_checker.sv
// hist_write_checker: in-line scoreboard for a multi-lane scratch-memory write
// stream. Expected transactions are queued in a small FIFO over a valid/ready
// port; every DUT write seen while running is compared against the FIFO head.
module hist_write_checker #(
    parameter int ADDR_W     = 16,
    parameter int LANES      = 4,
    parameter int LANE_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [CNT_W-1:0]        exp_total,
    input  logic                    exp_valid,
    output logic                    exp_ready,
    input  logic [ADDR_W-1:0]       exp_addr,
    input  logic [LANES*LANE_W-1:0] exp_data,
    input  logic [LANES-1:0]        lane_mask,
    input  logic                    dut_we,
    input  logic [ADDR_W-1:0]       dut_addr,
    input  logic [LANES*LANE_W-1:0] dut_wdata,
    output logic [CNT_W-1:0]        pass_count,
    output logic [CNT_W-1:0]        mismatch_count,
    output logic                    first_err_valid,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic [LANES-1:0]        first_err_lanes,
    output logic                    underflow,
    output logic                    timeout,
    output logic                    done
);

    localparam int DATA_W  = LANES * LANE_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0]   PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_ONE = 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [PTR_W-1:0]  rd_idx;
    logic              full, empty, push, pop, check;
    logic              underflow_hit, fail, stall_hit;
    logic [LANES-1:0]  lane_diff;
    logic [CNT_W:0]    compared;
    logic [STALL_W-1:0] stall_cnt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign rd_idx = rd_ptr[PTR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign exp_ready = !full;

    // A write only sees entries already in the FIFO: no push-to-pop bypass.
    assign check = (state_q == RUN) && dut_we;
    assign pop   = check && !empty;
    // A full FIFO popping this cycle frees a slot, so the push still lands
    // even though exp_ready (which only reflects full) reads low.
    assign push  = exp_valid && (!full || pop);

    assign underflow_hit = check && empty;
    assign fail = underflow_hit ||
                  (pop && ((dut_addr != fifo_addr[rd_idx]) || (|lane_diff)));
    assign compared  = {1'b0, pass_count} + {1'b0, mismatch_count};
    assign stall_hit = (state_q == RUN) && !dut_we && (stall_cnt == STALL_LAST);

    // Per-lane compare against the FIFO head, gated by the lane mask.
    always_comb begin
        lane_diff = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_diff[i] = lane_mask[i] &&
                (dut_wdata[i*LANE_W +: LANE_W] != fifo_data[rd_idx][i*LANE_W +: LANE_W]);
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and done decode; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if ((compared == {1'b0, exp_total}) || stall_hit) state_d = DONE;
            DONE: done = 1'b1;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // FIFO storage; contents need no reset, the pointers define validity.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= exp_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= exp_data;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Result counters, sticky flags and first-error capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_count      <= '0;
            mismatch_count  <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_lanes <= '0;
            underflow       <= 1'b0;
            timeout         <= 1'b0;
        end else if (clear) begin
            pass_count      <= '0;
            mismatch_count  <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_lanes <= '0;
            underflow       <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            if (pop && !fail && (pass_count != CNT_MAX))
                pass_count <= pass_count + CNT_ONE;
            if (fail && (mismatch_count != CNT_MAX))
                mismatch_count <= mismatch_count + CNT_ONE;
            if (underflow_hit)
                underflow <= 1'b1;
            if (fail && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= dut_addr;
                first_err_lanes <= underflow_hit ? {LANES{1'b1}} : lane_diff;
            end
            if (stall_hit)
                timeout <= 1'b1;
        end
    end

    // Stall counter: counts idle RUN cycles, restarts on any write or outside RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                           stall_cnt <= '0;
        else if (clear)                      stall_cnt <= '0;
        else if (state_q != RUN || dut_we)   stall_cnt <= '0;
        else                                 stall_cnt <= stall_cnt + STALL_ONE;
    end

endmodule

// File: tb/tb_hist_write_checker.sv
// Directed bench for hist_write_checker: table-driven image runs plus
// hand-written sequences for underflow, full-FIFO, timeout and reset/clear.
module tb_hist_write_checker;

    localparam int ADDR_W = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam int TMO    = 16;
    localparam int DW     = LANES * LANE_W;

    logic              clock = 1'b0;
    logic              reset, enable, clear;
    logic [CNT_W-1:0]  exp_total;
    logic              exp_valid, exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DW-1:0]     exp_data;
    logic [LANES-1:0]  lane_mask;
    logic              dut_we;
    logic [ADDR_W-1:0] dut_addr;
    logic [DW-1:0]     dut_wdata;
    logic [CNT_W-1:0]  pass_count, mismatch_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;
    logic [LANES-1:0]  first_err_lanes;
    logic              underflow, timeout, done;

    hist_write_checker #(
        .ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W),
        .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .exp_total(exp_total), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_addr(exp_addr), .exp_data(exp_data), .lane_mask(lane_mask),
        .dut_we(dut_we), .dut_addr(dut_addr), .dut_wdata(dut_wdata),
        .pass_count(pass_count), .mismatch_count(mismatch_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .first_err_lanes(first_err_lanes), .underflow(underflow),
        .timeout(timeout), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     edat;
        logic [DW-1:0]     ddat;
        logic [LANES-1:0]  mask;
        logic              mis;
    } vec_t;

    vec_t tbl [24];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
        exp_valid = 1'b1; exp_addr = a; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
        dut_we = 1'b1; dut_addr = a; dut_wdata = d;
        tick();
        dut_we = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic start(input int total);
        exp_total = CNT_W'(total);
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    function automatic logic [DW-1:0] mkdat(input int base);
        logic [DW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*LANE_W +: LANE_W] = 32'(base + k);
        return d;
    endfunction

    initial begin
        int ep, em;
        vec_t v;

        // Group 0: exact matches. Group 1: entry 3 lane2 0x5 vs 0x7.
        // Group 2: same corruption, lane 2 masked off.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 8; i++) begin
                tbl[g*8+i].addr = 16'h1000 + 16'(g*16 + i);
                tbl[g*8+i].edat = mkdat(g*256 + i*16);
                tbl[g*8+i].ddat = mkdat(g*256 + i*16);
                tbl[g*8+i].mask = 4'hF;
                tbl[g*8+i].mis  = 1'b0;
            end
        end
        tbl[11].edat[95:64] = 32'h5; tbl[11].ddat[95:64] = 32'h7; tbl[11].mis = 1'b1;
        tbl[19].edat[95:64] = 32'h5; tbl[19].ddat[95:64] = 32'h7;
        for (int i = 16; i < 24; i++) tbl[i].mask = 4'b1011;

        reset = 1'b0; enable = 1'b0; clear = 1'b0; exp_total = '0;
        exp_valid = 1'b0; exp_addr = '0; exp_data = '0; lane_mask = 4'hF;
        dut_we = 1'b0; dut_addr = '0; dut_wdata = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_pass", pass_count, 0);
        chk("rst_mis", mismatch_count, 0);
        chk("rst_fev", first_err_valid, 0);
        chk("rst_flags", {underflow, timeout, done}, 0);
        chk("rst_ready", exp_ready, 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();

        // Table-driven image runs.
        for (int g = 0; g < 3; g++) begin
            clr();
            for (int i = 0; i < 8; i++) push_exp(tbl[g*8+i].addr, tbl[g*8+i].edat);
            if (g == 0) chk("full_ready", exp_ready, 0);
            start(8);
            ep = 0; em = 0;
            for (int i = 0; i < 8; i++) begin
                v = tbl[g*8+i];
                lane_mask = v.mask;
                write(v.addr, v.ddat);
                if (v.mis) em++; else ep++;
                chk("tbl_pass", pass_count, CNT_W'(ep));
                chk("tbl_mis", mismatch_count, CNT_W'(em));
            end
            tick();
            chk("tbl_done", done, 1);
            chk("tbl_flags", {underflow, timeout}, 0);
            if (g == 1) begin
                chk("t2_fev", first_err_valid, 1);
                chk("t2_lanes", first_err_lanes, 4'b0100);
                chk("t2_addr", first_err_addr, tbl[11].addr);
            end else begin
                chk("tbl_fev", first_err_valid, 0);
            end
            if (g == 0) begin
                write(16'h0, '0);
                chk("done_ignores_we", pass_count, 8);
            end
        end
        lane_mask = 4'hF;

        // T3: write against an empty FIFO while the matching push lands.
        clr();
        start(2);
        exp_valid = 1'b1; exp_addr = 16'h2222; exp_data = mkdat(32'h2200);
        dut_we = 1'b1; dut_addr = 16'h2222; dut_wdata = mkdat(32'h2200);
        tick();
        exp_valid = 1'b0; dut_we = 1'b0;
        chk("t3_underflow", underflow, 1);
        chk("t3_mis", mismatch_count, 1);
        chk("t3_pass0", pass_count, 0);
        chk("t3_lanes", first_err_lanes, 4'hF);
        chk("t3_addr", first_err_addr, 16'h2222);
        write(16'h2222, mkdat(32'h2200));
        chk("t3_pass1", pass_count, 1);
        tick();
        chk("t3_done", done, 1);

        // T4: full FIFO pushes and pops in the same cycle.
        clr();
        for (int i = 0; i < 8; i++) push_exp(16'h3000 + 16'(i), mkdat(32'h3000 + i*16));
        chk("t4_full", exp_ready, 0);
        start(9);
        exp_valid = 1'b1; exp_addr = 16'h3008; exp_data = mkdat(32'h3080);
        dut_we = 1'b1; dut_addr = 16'h3000; dut_wdata = mkdat(32'h3000);
        tick();
        exp_valid = 1'b0; dut_we = 1'b0;
        chk("t4_ready_low", exp_ready, 0);
        chk("t4_pass1", pass_count, 1);
        for (int i = 1; i < 9; i++) write(16'h3000 + 16'(i), mkdat(32'h3000 + i*16));
        chk("t4_pass9", pass_count, 9);
        chk("t4_mis", mismatch_count, 0);
        chk("t4_uf", underflow, 0);
        chk("t4_ready", exp_ready, 1);
        tick();
        chk("t4_done", done, 1);

        // T5: stall timeout exactly TMO cycles after RUN entry.
        clr();
        start(5);
        repeat (TMO - 1) tick();
        chk("t5_early", {timeout, done}, 0);
        tick();
        chk("t5_timeout", timeout, 1);
        chk("t5_done", done, 1);

        // exp_total = 0: RUN for one cycle, then DONE.
        clr();
        start(0);
        chk("zero_run", done, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_tmo", timeout, 0);

        // T6: asynchronous reset mid-image, then a fresh run, then clear.
        clr();
        for (int i = 0; i < 3; i++) push_exp(16'h4000 + 16'(i), mkdat(32'h4000 + i*16));
        start(3);
        write(16'h4000, mkdat(32'h4000));
        chk("t6_pre", pass_count, 1);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_cnt", {pass_count, mismatch_count}, 0);
        chk("t6_rst_ready", exp_ready, 1);
        chk("t6_rst_flags", {first_err_valid, underflow, timeout, done}, 0);
        #2 reset = 1'b0;
        tick();
        write(16'h4001, mkdat(32'h4010));
        chk("t6_idle_ignore", {pass_count, mismatch_count, underflow}, 0);
        push_exp(16'h5000, mkdat(32'h5000));
        start(1);
        write(16'h5000, mkdat(32'h5000));
        chk("t6_fresh_pass", pass_count, 1);
        chk("t6_fresh_mis", mismatch_count, 0);
        tick();
        chk("t6_done", done, 1);
        clr();
        chk("t6_clr_cnt", {pass_count, mismatch_count}, 0);
        chk("t6_clr_flags", {first_err_valid, underflow, timeout, done}, 0);
        chk("t6_clr_ready", exp_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
